upsample_layer_sequencer: RTL and testbench

- Channel-level sequencer for the 2x upsample engine.
- For each of cfg_num_ch channels it performs four steps in order:
  - Fills the engine's input tile buffer from an upstream valid/ready stream.
  - Pulses the engine's start and waits for its done.
  - Drains the engine's output tile buffer to a downstream valid/ready stream.
  - Advances to the next channel.
- Sits between the layer DMA/stream fabric and the upsample control unit and its buffers. Channels are processed strictly one at a time; fill and drain are not overlapped.

---
 rtl/upsample_pkg.sv | 18 +
 rtl/upsample_skid_fifo.sv | 49 ++++
 rtl/upsample_layer_sequencer.sv | 174 +++++++++++++++++
 tb/tb_upsample_layer_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/upsample_pkg.sv
// Shared definitions for the 2x upsample channel sequencer.
package upsample_pkg;

    localparam int IN_WORDS_DEF  = 16;
    localparam int OUT_WORDS_DEF = 64;
    localparam int ADDR_W        = 6;
    localparam int SKID_DEPTH    = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_KICK    = 3'd2,
        ST_WAIT_UP = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_FINISH  = 3'd5
    } state_t;

endpackage

// File: rtl/upsample_skid_fifo.sv
// Two-entry registered FIFO that absorbs output-buffer read data while the
// downstream stream is stalled.
module upsample_skid_fifo
    import upsample_pkg::*;
#(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [SKID_DEPTH];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    // Storage, pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/upsample_layer_sequencer.sv
// Channel-level sequencer: fill input tile, kick engine, drain output tile.
//
// state      | meaning
// IDLE       | waiting for start
// FILL       | accepting IN_WORDS upstream words into the input buffer
// KICK       | one-cycle up_start pulse to the engine
// WAIT_UP    | waiting for the engine's up_done
// DRAIN      | reading OUT_WORDS from the output buffer to the downstream stream
// FINISH     | one-cycle done pulse, then back to IDLE
module upsample_layer_sequencer
    import upsample_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int IN_WORDS  = IN_WORDS_DEF,
    parameter int OUT_WORDS = OUT_WORDS_DEF,
    parameter int CH_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CH_W-1:0]   cfg_num_ch,
    output logic              busy,
    output logic              done,
    output logic [CH_W-1:0]   ch_idx,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              in_we,
    output logic [ADDR_W-1:0] in_addr,
    output logic [DATA_W-1:0] in_wdata,
    output logic              up_start,
    input  logic              up_done,
    output logic              out_re,
    output logic [ADDR_W-1:0] out_addr,
    input  logic [DATA_W-1:0] out_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    localparam int WR_W = $clog2(IN_WORDS + 1);
    localparam int RD_W = $clog2(OUT_WORDS + 1);

    state_t            state_q, state_d;
    logic [CH_W-1:0]   num_ch_q;
    logic [CH_W-1:0]   ch_idx_q;
    logic [WR_W-1:0]   wr_cnt_q;
    logic [RD_W-1:0]   rd_cnt_q;
    logic              rd_pend_q;
    logic              rd_last_q;

    logic              accept;
    logic              pop;
    logic              last_pop;
    logic              final_ch;
    logic [1:0]        fifo_count;
    logic [1:0]        outstanding;
    logic [DATA_W:0]   fifo_head;

    // The read issued last cycle returns now; it lands in the skid FIFO
    // together with its end-of-tile flag.
    upsample_skid_fifo #(.W(DATA_W + 1)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_pend_q),
        .pop       (pop),
        .push_data ({rd_last_q, out_rdata}),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign s_ready  = (state_q == ST_FILL);
    assign accept   = s_valid & s_ready;
    assign in_we    = accept;
    assign in_addr  = accept ? ADDR_W'(wr_cnt_q) : '0;
    assign in_wdata = accept ? s_data : '0;

    assign m_valid  = (fifo_count != 2'd0);
    assign pop      = m_valid & m_ready;
    assign m_data   = m_valid ? fifo_head[DATA_W-1:0] : '0;
    assign m_last   = m_valid & fifo_head[DATA_W];
    assign last_pop = pop & m_last;
    assign final_ch = (ch_idx_q == num_ch_q - CH_W'(1));

    // Reads in flight or parked in the FIFO; capped at the FIFO depth so a
    // returning word always has a slot.
    assign outstanding = fifo_count + {1'b0, rd_pend_q};
    assign out_re      = (state_q == ST_DRAIN) && (rd_cnt_q < RD_W'(OUT_WORDS))
                         && ((outstanding - {1'b0, pop}) < 2'd2);
    assign out_addr    = out_re ? ADDR_W'(rd_cnt_q) : '0;
    assign ch_idx      = ch_idx_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and state-owned strobes.
    always_comb begin
        state_d  = state_q;
        busy     = (state_q != ST_IDLE);
        done     = 1'b0;
        up_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (cfg_num_ch != '0) ? ST_FILL : ST_FINISH;
                end
            end
            ST_FILL: begin
                if (accept && (wr_cnt_q == WR_W'(IN_WORDS - 1))) begin
                    state_d = ST_KICK;
                end
            end
            ST_KICK: begin
                up_start = 1'b1;
                state_d  = ST_WAIT_UP;
            end
            ST_WAIT_UP: begin
                if (up_done) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_pop) begin
                    state_d = final_ch ? ST_FINISH : ST_FILL;
                end
            end
            ST_FINISH: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Channel bookkeeping, word counters and read-return tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_ch_q  <= '0;
            ch_idx_q  <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            rd_pend_q <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            rd_pend_q <= out_re;
            rd_last_q <= out_re && (rd_cnt_q == RD_W'(OUT_WORDS - 1));
            if ((state_q == ST_IDLE) && start) begin
                num_ch_q <= cfg_num_ch;
                ch_idx_q <= '0;
                wr_cnt_q <= '0;
                rd_cnt_q <= '0;
            end else if ((state_q == ST_DRAIN) && last_pop && !final_ch) begin
                ch_idx_q <= ch_idx_q + CH_W'(1);
                wr_cnt_q <= '0;
                rd_cnt_q <= '0;
            end else begin
                if (accept) begin
                    wr_cnt_q <= wr_cnt_q + WR_W'(1);
                end
                if (out_re) begin
                    rd_cnt_q <= rd_cnt_q + RD_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_upsample_layer_sequencer.sv
// Scoreboard bench for the upsample channel sequencer.
module tb_upsample_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cfg_num_ch = '0;
    logic        busy, done;
    logic [7:0]  ch_idx;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = '0;
    logic        in_we;
    logic [5:0]  in_addr;
    logic [15:0] in_wdata;
    logic        up_start;
    logic        up_done = 1'b0;
    logic        out_re;
    logic [5:0]  out_addr;
    logic [15:0] out_rdata = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] m_data;
    logic        m_last;

    upsample_layer_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .cfg_num_ch(cfg_num_ch),
        .busy(busy), .done(done), .ch_idx(ch_idx),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .in_we(in_we), .in_addr(in_addr), .in_wdata(in_wdata),
        .up_start(up_start), .up_done(up_done),
        .out_re(out_re), .out_addr(out_addr), .out_rdata(out_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  ch;
        logic        last;
        logic        fin;
        logic [15:0] data;
    } beat_t;

    logic [21:0] in_q [$];
    logic [5:0]  addr_q [$];
    beat_t       m_q [$];
    logic [21:0] e_in;
    logic [5:0]  e_addr;
    beat_t       e_beat;

    int checks = 0, errors = 0;
    int cyc = 0, exp_done = -1;
    int up_cnt = 0, sr_cnt = 0, re_cnt = 0, done_cnt = 0, m_beats = 0, outs = 0;
    bit acc_seen = 0, saw_up = 0, rd_req = 0;
    logic [15:0] rd_data = '0;
    int src_idx = 0, ud_cnt = 0;
    bit src_en = 0, rnd_ready = 0, spur_ud = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {4'b0, busy, done, ch_idx, s_ready, in_we, in_addr, in_wdata, up_start,
                out_re, out_addr, m_valid, m_data, m_last};
    endfunction

    // Responders: upstream source, engine done after 5 cycles, output buffer, m_ready.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (acc_seen) src_idx++;
        s_data  = 16'(src_idx);
        s_valid = src_en;
        if (saw_up) ud_cnt = 5;
        if (ud_cnt != 0) begin
            ud_cnt--;
            up_done = (ud_cnt == 0) | spur_ud;
        end else begin
            up_done = spur_ud;
        end
        m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rd_req) out_rdata = rd_data;
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            acc_seen = 0; saw_up = 0; rd_req = 0; outs = 0;
        end else begin
            acc_seen = s_valid & s_ready;
            saw_up   = up_start;
            rd_req   = out_re;
            if (s_ready) sr_cnt++;
            if (up_start) up_cnt++;
            if (in_we) begin
                if (in_q.size() == 0) chk("in_write_unexpected", 64'(in_addr), 64'hFFFF);
                else begin
                    e_in = in_q.pop_front();
                    chk("in_write", 64'({in_addr, in_wdata}), 64'(e_in));
                end
            end
            if (out_re) begin
                re_cnt++;
                rd_data = 16'(((int'(ch_idx) + 1) << 8) + int'(out_addr));
                if (addr_q.size() == 0) chk("out_addr_unexpected", 64'(out_addr), 64'hFFFF);
                else begin
                    e_addr = addr_q.pop_front();
                    chk("out_addr", 64'(out_addr), 64'(e_addr));
                end
            end
            if (m_valid && m_ready) begin
                m_beats++;
                outs--;
                if (m_q.size() == 0) chk("m_beat_unexpected", 64'(m_data), 64'hFFFF);
                else begin
                    e_beat = m_q.pop_front();
                    chk("m_beat", 64'({ch_idx, m_last, m_data}),
                        64'({e_beat.ch, e_beat.last, e_beat.data}));
                    if (e_beat.fin) exp_done = cyc + 1;
                end
            end
            if (out_re) begin
                outs++;
                chk("outstanding_le_2", 64'(outs <= 2), 64'd1);
            end
            if (done) begin
                done_cnt++;
                chk("done_cycle", 64'(cyc), 64'(exp_done));
            end
        end
    end

    task automatic start_run(input int nch);
        int base;
        base = src_idx;
        for (int ch = 0; ch < nch; ch++) begin
            for (int i = 0; i < 16; i++) in_q.push_back({6'(i), 16'(base + 16 * ch + i)});
            for (int i = 0; i < 64; i++) begin
                addr_q.push_back(6'(i));
                m_q.push_back('{ch: 8'(ch), last: (i == 63), fin: (i == 63 && ch == nch - 1),
                                data: 16'(((ch + 1) << 8) + i)});
            end
        end
        @(posedge clk); #1;
        start = 1'b1;
        cfg_num_ch = 8'(nch);
        if (nch == 0) exp_done = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int d0, n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < 4000) begin
            @(negedge clk); #1;
            n++;
        end
        chk({name, "_done_count"}, 64'(done_cnt - d0), 64'd1);
        @(negedge clk); #1;
        chk({name, "_idle_after"}, 64'({busy, done}), 64'd0);
        chk({name, "_sb_empty"}, 64'(in_q.size() + addr_q.size() + m_q.size()), 64'd0);
    endtask

    task automatic run_full(input int nch, input string name);
        int u0;
        u0 = up_cnt;
        start_run(nch);
        wait_done(name);
        chk({name, "_up_starts"}, 64'(up_cnt - u0), 64'(nch));
    endtask

    task automatic wait_beats(input int target);
        int n;
        n = 0;
        while (m_beats < target && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("beats_reached", 64'(m_beats >= target), 64'd1);
    endtask

    initial begin
        int u0, s0, r0, m0;
        #23;
        chk("reset_outputs", all_outs(), 64'd0);
        @(negedge clk); rst = 1'b1;
        src_en = 1'b1;

        run_full(1, "t1_single");
        run_full(3, "t2_three_ch");

        rnd_ready = 1'b1;
        run_full(1, "t3_random_ready");
        rnd_ready = 1'b0;

        s0 = sr_cnt; u0 = up_cnt; r0 = re_cnt;
        run_full(0, "t4_zero_ch");
        chk("t4_no_s_ready", 64'(sr_cnt - s0), 64'd0);
        chk("t4_no_up_start", 64'(up_cnt - u0), 64'd0);
        chk("t4_no_out_re", 64'(re_cnt - r0), 64'd0);

        src_en = 1'b0;
        u0 = up_cnt;
        start_run(1);
        repeat (3) @(posedge clk);
        #2 spur_ud = 1'b1;
        @(posedge clk); #2 spur_ud = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("t5_fill_held", 64'({busy, s_ready}), 64'b11);
        chk("t5_no_kick", 64'(up_cnt - u0), 64'd0);
        src_en = 1'b1;
        wait_done("t5_spur_up_done");
        chk("t5_one_kick", 64'(up_cnt - u0), 64'd1);

        rnd_ready = 1'b1;
        u0 = up_cnt;
        m0 = m_beats;
        start_run(1);
        wait_beats(m0 + 3);
        @(posedge clk); #1;
        start = 1'b1; cfg_num_ch = 8'd5;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        wait_done("t5_start_in_drain");
        chk("t5_drain_one_kick", 64'(up_cnt - u0), 64'd1);
        rnd_ready = 1'b0;

        m0 = m_beats;
        start_run(1);
        wait_beats(m0 + 10);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("t6_async_reset_outputs", all_outs(), 64'd0);
        repeat (2) @(posedge clk);
        in_q.delete();
        addr_q.delete();
        m_q.delete();
        exp_done = -1;
        @(negedge clk); rst = 1'b1;
        run_full(1, "t6_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
